pulpemu_board_io: RTL



---
 rtl/pulpemu_board_io.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pulpemu_board_io.sv
// pulpemu_board_io: board I/O conditioning and PULPino boot sequencer for the
// FPGA emulation top (ps7_clk domain). Switches/buttons are synchronised and
// debounced, buttons get rising-edge pulses, a HOLD/DELAY/RUN sequencer drives
// the PULPino reset and fetch enable, and the LEDs show either PULPino GPIO or
// an internal status view.
// Build option: define PULPEMU_BOARD_IO_LONGPRESS_EN to make the reset button
// act only on a long press (LONGPRESS_CYCLES) instead of on every press.

// One input bit: 2-flop synchroniser followed by a hold-time debouncer.
module pulpemu_board_io_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic ps7_clk,
    input  logic ps7_rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Synchronise, then accept a new level only after it held for DEBOUNCE_CYCLES samples
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pulpemu_board_io #(
    parameter int N_SW             = 8,
    parameter int N_BTN            = 5,
    parameter int N_LED            = 8,
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int RST_MIN_CYCLES   = 256,
    parameter int FETCH_DELAY      = 1024,
    parameter int BLINK_LOG2       = 24,
    parameter int LONGPRESS_CYCLES = 1000000
) (
    input  logic             ps7_clk,
    input  logic             ps7_rst_n,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [N_LED-1:0] gpio_led_i,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] btn_rise_o,
    output logic             pulp_rst_no,
    output logic             fetch_en_o,
    output logic [N_LED-1:0] led_o,
    output logic [1:0]       seq_state_o
);
    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2
    } seq_state_t;

    localparam int SEQ_MAX = (RST_MIN_CYCLES > FETCH_DELAY) ? RST_MIN_CYCLES : FETCH_DELAY;
    localparam int SCW     = $clog2(SEQ_MAX + 1);
    localparam logic [SCW-1:0] RST_LAST   = SCW'(RST_MIN_CYCLES - 1);
    localparam logic [SCW-1:0] FETCH_LAST = SCW'(FETCH_DELAY - 1);

    // Reject configurations the sequencer and LED map cannot support
    if (N_SW < 2 || N_BTN < 1 || N_LED < 4 || DEBOUNCE_CYCLES < 1 || RST_MIN_CYCLES < 1 ||
        FETCH_DELAY < 1 || BLINK_LOG2 < 1 || LONGPRESS_CYCLES < 2) begin : g_bad_params
        $error("pulpemu_board_io: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // Switch / button conditioning, one debouncer per bit
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        pulpemu_board_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .ps7_clk  (ps7_clk),
            .ps7_rst_n(ps7_rst_n),
            .raw      (sw_i[i]),
            .level    (sw_o[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        pulpemu_board_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .ps7_clk  (ps7_clk),
            .ps7_rst_n(ps7_rst_n),
            .raw      (btn_i[i]),
            .level    (btn_o[i])
        );
    end

    logic [N_BTN-1:0] btn_q;

    // Registered rising-edge detect on the debounced buttons
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            btn_q      <= '0;
            btn_rise_o <= '0;
        end else begin
            btn_q      <= btn_o;
            btn_rise_o <= btn_o & ~btn_q;
        end
    end

    // ------------------------------------------------------------------
    // GPIO LED field crossing in from the PULPino clock domain
    // ------------------------------------------------------------------
    logic [N_LED-1:0] gpio_q1;
    logic [N_LED-1:0] gpio_q2;

    // Plain 2-flop synchroniser; LEDs tolerate a skewed multi-bit update
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            gpio_q1 <= '0;
            gpio_q2 <= '0;
        end else begin
            gpio_q1 <= gpio_led_i;
            gpio_q2 <= gpio_q1;
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [BLINK_LOG2-1:0] hb_cnt;
    logic                  heartbeat;

    // Free-running wrap-around counter; its MSB blinks the status LED
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) hb_cnt <= '0;
        else            hb_cnt <= hb_cnt + 1'b1;
    end

    assign heartbeat = hb_cnt[BLINK_LOG2-1];

    // ------------------------------------------------------------------
    // Reset-button trigger
    // ------------------------------------------------------------------
    logic rst_trig;
    logic hold_force;

`ifdef PULPEMU_BOARD_IO_LONGPRESS_EN
    localparam int LPW = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [LPW-1:0] LP_LAST = LPW'(LONGPRESS_CYCLES - 1);

    logic [LPW-1:0] lp_cnt;
    logic           lp_fired;

    // Fires once per press, on the cycle the held count reaches the threshold
    assign rst_trig   = btn_o[0] && (lp_cnt == LP_LAST) && !lp_fired;
    // After a long press, keep PULPino in reset until the button is let go
    assign hold_force = lp_fired && btn_o[0];

    // Count how long button 0 has been held; saturate and remember the trigger
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
        end else if (!btn_o[0]) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
        end else begin
            if (lp_cnt != LP_LAST) lp_cnt <= lp_cnt + 1'b1;
            if (rst_trig)          lp_fired <= 1'b1;
        end
    end
`else
    // Every debounced press of button 0 restarts the target
    assign rst_trig   = btn_rise_o[0];
    assign hold_force = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Reset / fetch-enable sequencer
    // ------------------------------------------------------------------
    seq_state_t     state;
    logic [SCW-1:0] seq_cnt;
    logic           abort;

    assign abort       = !sw_o[1] || rst_trig || hold_force;
    assign seq_state_o = state;

    // HOLD keeps the core in reset for a minimum time, DELAY lets it come out
    // of reset before fetching, RUN follows the fetch switch; outputs are
    // registered from the next state so an abort drops reset on the same edge
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state       <= S_HOLD;
            seq_cnt     <= '0;
            pulp_rst_no <= 1'b0;
            fetch_en_o  <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    pulp_rst_no <= 1'b0;
                    fetch_en_o  <= 1'b0;
                    if (rst_trig || hold_force) begin
                        seq_cnt <= '0;
                    end else if (seq_cnt == RST_LAST) begin
                        if (sw_o[1]) begin
                            state       <= S_DELAY;
                            seq_cnt     <= '0;
                            pulp_rst_no <= 1'b1;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    fetch_en_o <= 1'b0;
                    if (abort) begin
                        state       <= S_HOLD;
                        seq_cnt     <= '0;
                        pulp_rst_no <= 1'b0;
                    end else if (seq_cnt == FETCH_LAST) begin
                        state       <= S_RUN;
                        seq_cnt     <= '0;
                        pulp_rst_no <= 1'b1;
                    end else begin
                        seq_cnt     <= seq_cnt + 1'b1;
                        pulp_rst_no <= 1'b1;
                    end
                end
                S_RUN: begin
                    seq_cnt <= '0;
                    if (abort) begin
                        state       <= S_HOLD;
                        pulp_rst_no <= 1'b0;
                        fetch_en_o  <= 1'b0;
                    end else begin
                        pulp_rst_no <= 1'b1;
                        fetch_en_o  <= sw_o[0];
                    end
                end
                default: begin
                    state       <= S_HOLD;
                    seq_cnt     <= '0;
                    pulp_rst_no <= 1'b0;
                    fetch_en_o  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // LED mux
    // ------------------------------------------------------------------
    logic [N_LED-1:0] led_stat;

    // Status view: fetch, reset, heartbeat, button 0; upper LEDs dark
    always_comb begin
        led_stat      = '0;
        led_stat[0]   = fetch_en_o;
        led_stat[1]   = pulp_rst_no;
        led_stat[2]   = heartbeat;
        led_stat[3]   = btn_o[0];
    end

    // Top switch selects status view over PULPino GPIO
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) led_o <= '0;
        else            led_o <= sw_o[N_SW-1] ? led_stat : gpio_q2;
    end
endmodule
